// File: rtl/latency_ctrl_pkg.sv
// latency_ctrl_pkg: shared types for the latency-measurement sequencer
package latency_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    ARM     = 6'b000010,
    WINDOW  = 6'b000100,
    DRAIN   = 6'b001000,
    CAPTURE = 6'b010000,
    REPORT  = 6'b100000
  } state_t;

  typedef struct packed {
    cnt_t issue_cnt;
    cnt_t aggregate_cnt;
    logic timeout;
  } result_t;

endpackage

// File: rtl/latency_ctrl_updn.sv
// latency_ctrl_updn: saturating up/down counter with load and rail flags
module latency_ctrl_updn
  import latency_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         ovf_o,
  output logic         unf_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic up, dn;

  assign up    = inc_i && !dec_i && !load_i;
  assign dn    = dec_i && !inc_i && !load_i;
  assign ovf_o = up && (&cnt_q);
  assign unf_o = dn && (cnt_q == '0);
  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

  // load wins; otherwise step one, holding at either rail
  always_comb
    cnt_d = load_i ? val_i :
            (up && !ovf_o) ? cnt_q + W'(1) :
            (dn && !unf_o) ? cnt_q - W'(1) : cnt_q;

  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

endmodule

// File: rtl/latency_ctrl.sv
// latency_ctrl: runs one latency-measurement episode per start pulse
module latency_ctrl
  import latency_ctrl_pkg::*;
#(
  parameter int W     = 32,
  parameter int WIN_W = 16,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             issue_in,
  input  logic             retire_in,
  output logic             lat_clear,
  output logic             lat_issue,
  output logic             lat_retire,
  input  logic [W-1:0]     lat_issue_cnt,
  input  logic [W-1:0]     lat_aggregate_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_issue_cnt,
  output logic [W-1:0]     res_aggregate_cnt,
  output logic             res_timeout,
  output logic             busy,
  output logic             err
);

  state_t           state_q, state_d;
  result_t          res_q, res_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             err_q, err_d;
  logic [W-1:0]     out_cnt, out_nxt, skip_cnt, skip_nxt, trk_cnt, trk_nxt;
  logic             out_ovf, out_unf, skip_ovf, skip_unf, trk_ovf, trk_unf;
  logic             tracking, abort, fwd, arm;
  logic             skip_dec, trk_inc, trk_dec;
  logic             unused_ok;

  // retires first consume the pre-window backlog, then count against tracked
  assign tracking = state_q == WINDOW || state_q == DRAIN;
  assign abort    = stop && (state_q inside {ARM, WINDOW, DRAIN, CAPTURE});
  assign arm      = state_q == ARM;
  assign fwd      = retire_in && skip_cnt == '0;
  assign skip_dec = tracking && retire_in && !fwd;
  assign trk_dec  = tracking && fwd;
  assign trk_inc  = state_q == WINDOW && issue_in;

  latency_ctrl_updn #(.W(W)) u_out (
    .clk(clk), .rst_n(rst_n), .load_i(1'b0), .val_i('0),
    .inc_i(issue_in), .dec_i(retire_in),
    .cnt_o(out_cnt), .nxt_o(out_nxt), .ovf_o(out_ovf), .unf_o(out_unf)
  );

  latency_ctrl_updn #(.W(W)) u_skip (
    .clk(clk), .rst_n(rst_n), .load_i(arm), .val_i(out_nxt),
    .inc_i(1'b0), .dec_i(skip_dec),
    .cnt_o(skip_cnt), .nxt_o(skip_nxt), .ovf_o(skip_ovf), .unf_o(skip_unf)
  );

  latency_ctrl_updn #(.W(W)) u_trk (
    .clk(clk), .rst_n(rst_n), .load_i(arm), .val_i('0),
    .inc_i(trk_inc), .dec_i(trk_dec),
    .cnt_o(trk_cnt), .nxt_o(trk_nxt), .ovf_o(trk_ovf), .unf_o(trk_unf)
  );

  assign unused_ok = ^{out_cnt, skip_nxt, skip_ovf, skip_unf, trk_cnt, trk_ovf, trk_unf};

  // episode sequencing, gated datapath strobes and result capture
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    win_d      = win_q;
    to_d       = '0;
    lat_clear  = 1'b0;
    lat_issue  = 1'b0;
    lat_retire = tracking && fwd;
    case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM: begin
        lat_clear = 1'b1;
        win_d     = cfg_window == '0 ? '0 : cfg_window - WIN_W'(1);
        state_d   = WINDOW;
      end
      WINDOW: begin
        lat_issue = issue_in;
        win_d     = win_q - WIN_W'(1);
        if (win_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        to_d = to_q + TO_W'(1);
        if (trk_nxt == '0) begin
          state_d       = CAPTURE;
          res_d.timeout = 1'b0;
        end else if (cfg_timeout != '0 && to_q == cfg_timeout - TO_W'(1)) begin
          state_d       = CAPTURE;
          res_d.timeout = 1'b1;
        end
      end
      CAPTURE: begin
        res_d.issue_cnt     = cnt_t'(lat_issue_cnt);
        res_d.aggregate_cnt = cnt_t'(lat_aggregate_cnt);
        state_d             = REPORT;
      end
      REPORT: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      res_d      = res_q;
      lat_clear  = 1'b0;
      lat_issue  = 1'b0;
      lat_retire = 1'b0;
    end
  end

  // error is sticky until an accepted start; saturation on the global count sets it
  always_comb err_d = ((state_q == IDLE && start) ? 1'b0 : err_q) | out_ovf | out_unf;

  // episode registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      win_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      win_q   <= win_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end

  assign res_valid         = state_q == REPORT;
  assign busy              = state_q != IDLE;
  assign err               = err_q;
  assign res_issue_cnt     = W'(res_q.issue_cnt);
  assign res_aggregate_cnt = W'(res_q.aggregate_cnt);
  assign res_timeout       = res_q.timeout;

endmodule

// File: tb/tb_latency_ctrl.sv
// tb_latency_ctrl: episode-level reference model against latency_ctrl
module tb_latency_ctrl;

  localparam int W     = 32;
  localparam int WIN_W = 16;
  localparam int TO_W  = 16;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic             issue_in = 1'b0, retire_in = 1'b0, res_ready = 1'b0;
  logic [WIN_W-1:0] cfg_window = '0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic             lat_clear, lat_issue, lat_retire, res_valid, res_timeout, busy, err;
  logic [W-1:0]     lat_issue_cnt = '0, lat_aggregate_cnt = '0, infl = '0;
  logic [W-1:0]     res_issue_cnt, res_aggregate_cnt;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int q_t[$];
  bit q_trk[$];
  int exp_issue = 0, exp_agg = 0;
  bit exp_to = 1'b0;
  bit iss, ret;

  latency_ctrl #(.W(W), .WIN_W(WIN_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_window(cfg_window), .cfg_timeout(cfg_timeout),
    .issue_in(issue_in), .retire_in(retire_in),
    .lat_clear(lat_clear), .lat_issue(lat_issue), .lat_retire(lat_retire),
    .lat_issue_cnt(lat_issue_cnt), .lat_aggregate_cnt(lat_aggregate_cnt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_issue_cnt(res_issue_cnt), .res_aggregate_cnt(res_aggregate_cnt),
    .res_timeout(res_timeout), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // stand-in for the external datapath: issue count and per-cycle in-flight sum
  always @(posedge clk)
    if (lat_clear) begin
      lat_issue_cnt     <= '0;
      lat_aggregate_cnt <= '0;
      infl              <= '0;
    end else begin
      lat_issue_cnt     <= lat_issue_cnt + W'(lat_issue);
      lat_aggregate_cnt <= lat_aggregate_cnt + infl;
      infl              <= infl + W'(lat_issue) - W'(lat_retire);
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ntrk();
    int s = 0;
    foreach (q_trk[i]) s += int'(q_trk[i]);
    return s;
  endfunction

  // ph: 0 outside measurement, 1 arm, 2 window, 3 drain
  task automatic tick(input int ph, input bit i_b, input bit r_b);
    bit fwd;
    fwd = r_b && q_t.size() > 0 && (ph == 2 || ph == 3) && q_trk[0];
    issue_in  = i_b;
    retire_in = r_b;
    #1;
    chk("lat_clear", lat_clear, ph == 1 && !stop);
    chk("lat_issue", lat_issue, i_b && ph == 2 && !stop);
    chk("lat_retire", lat_retire, fwd && !stop);
    @(posedge clk);
    cyc++;
    if (r_b && q_t.size() > 0) begin
      if (fwd && !stop) exp_agg += cyc - q_t[0];
      q_t.delete(0);
      q_trk.delete(0);
    end
    if (i_b) begin
      q_t.push_back(cyc);
      q_trk.push_back(ph == 2 && !stop);
      if (ph == 2 && !stop) exp_issue++;
    end
    #1;
    issue_in  = 1'b0;
    retire_in = 1'b0;
  endtask

  task automatic pick(input int k, input logic [31:0] ip, input logic [31:0] rp,
                      input bit rnd, output bit i_o, output bit r_o);
    i_o = rnd ? ($urandom_range(0, 99) < 35) : (k < 32 && ip[k]);
    r_o = rnd ? (q_t.size() > 0 && $urandom_range(0, 99) < 45) : (k < 32 && rp[k]);
  endtask

  task automatic res_chk(input string tag, input bit v);
    chk({tag, "_valid"}, res_valid, v);
    chk({tag, "_busy"}, busy, v);
    chk({tag, "_issue"}, res_issue_cnt, exp_issue);
    chk({tag, "_aggregate"}, res_aggregate_cnt, exp_agg);
    chk({tag, "_timeout"}, res_timeout, exp_to);
  endtask

  task automatic episode(input int n, input int to, input logic [31:0] ip,
                         input logic [31:0] rp, input bit rnd, input int hold);
    int k, didx;
    bit i_b, r_b, done;
    k = 0;
    didx = 0;
    done = 1'b0;
    cfg_window  = WIN_W'(n);
    cfg_timeout = TO_W'(to);
    exp_issue = 0;
    exp_agg   = 0;
    exp_to    = 1'b0;
    foreach (q_trk[i]) q_trk[i] = 1'b0;
    start = 1'b1;
    tick(0, 1'b0, 1'b0);
    start = 1'b0;
    chk("armed_busy", busy, 1);
    chk("start_clears_err", err, 0);
    pick(k, ip, rp, rnd, i_b, r_b); tick(1, i_b, r_b); k++;
    repeat (n == 0 ? 1 : n) begin
      pick(k, ip, rp, rnd, i_b, r_b); tick(2, i_b, r_b); k++;
    end
    while (!done) begin
      pick(k, ip, rp, rnd, i_b, r_b); tick(3, i_b, r_b); k++;
      if (ntrk() == 0) done = 1'b1;
      else if (to != 0 && didx == to - 1) begin
        done   = 1'b1;
        exp_to = 1'b1;
        foreach (q_t[i]) if (q_trk[i]) exp_agg += cyc - q_t[i];
      end
      didx++;
      if (didx > 2000) begin
        $display("FAIL drain_bound: reference drain exceeded %0d cycles", didx);
        $fatal(1);
      end
    end
    pick(99, ip, rp, rnd, i_b, r_b); tick(0, i_b, r_b);
    res_chk("report", 1'b1);
    for (int h = 0; h < hold; h++) begin
      start = (h == 0);
      pick(99, ip, rp, rnd, i_b, r_b); tick(0, i_b, r_b);
      start = 1'b0;
      res_chk("stall", 1'b1);
    end
    res_ready = 1'b1;
    pick(99, ip, rp, rnd, i_b, r_b); tick(0, i_b, r_b);
    res_ready = 1'b0;
    res_chk("handshake", 1'b0);
    tick(0, 1'b0, 1'b0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_issue", res_issue_cnt, 0);
    chk("rst_aggregate", res_aggregate_cnt, 0);
    chk("rst_timeout", res_timeout, 0);
    chk("rst_clear", lat_clear, 0);

    // basic episode with ten cycles of backpressure
    episode(4, 0, 32'h2, 32'h10, 1'b0, 10);

    // pre-window backlog of two is skipped
    tick(0, 1'b1, 1'b0);
    tick(0, 1'b1, 1'b0);
    episode(2, 0, 32'h2, 32'h1C, 1'b0, 0);

    // drain timeout after five cycles
    episode(1, 5, 32'h2, 32'h0, 1'b0, 1);

    // randomized traffic, windows and timeouts
    for (int e = 0; e < 10; e++) begin
      repeat (3) begin
        pick(0, 32'h0, 32'h0, 1'b1, iss, ret);
        tick(0, iss, ret);
      end
      episode(int'($urandom_range(0, 6)),
              $urandom_range(0, 1) != 0 ? 0 : int'($urandom_range(2, 12)),
              32'h0, 32'h0, 1'b1, int'($urandom_range(0, 4)));
    end

    // stop mid-window
    cfg_window  = WIN_W'(5);
    cfg_timeout = '0;
    foreach (q_trk[i]) q_trk[i] = 1'b0;
    start = 1'b1; tick(0, 1'b0, 1'b0); start = 1'b0;
    tick(1, 1'b0, 1'b0);
    tick(2, 1'b1, 1'b0);
    tick(2, 1'b0, 1'b0);
    stop = 1'b1; tick(2, 1'b1, 1'b0); stop = 1'b0;
    chk("stop_idle", busy, 0);
    chk("stop_no_report", res_valid, 0);
    repeat (3) begin
      tick(0, 1'b0, 1'b0);
      chk("stop_quiet", res_valid, 0);
    end

    // asynchronous reset mid-drain
    cfg_window = WIN_W'(1);
    foreach (q_trk[i]) q_trk[i] = 1'b0;
    start = 1'b1; tick(0, 1'b0, 1'b0); start = 1'b0;
    tick(1, 1'b0, 1'b0);
    tick(2, 1'b1, 1'b0);
    tick(3, 1'b0, 1'b0);
    tick(3, 1'b0, 1'b0);
    chk("drain_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", res_valid, 0);
    q_t.delete();
    q_trk.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("arst_res_cleared", res_issue_cnt, 0);
    repeat (3) begin
      tick(0, 1'b0, 1'b0);
      chk("arst_quiet", res_valid, 0);
    end

    // retire with nothing outstanding
    tick(0, 1'b0, 1'b1);
    chk("underflow_err", err, 1);
    tick(0, 1'b0, 1'b0);
    chk("err_sticky", err, 1);
    episode(1, 8, 32'h2, 32'h4, 1'b0, 0);
    chk("err_stays_clear", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
